// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, constants and helpers for the dynamic integer clock divider
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } clk_div_state_e;

  localparam int CLK_DIV_MIN   = 2;
  localparam int CLK_DIV_MAX_W = 32;

  // Number of source cycles clk_p stays high in one period: ceil(N/2), one bit wider than N.
  function automatic logic [CLK_DIV_MAX_W:0] hi_cycles(input logic [CLK_DIV_MAX_W-1:0] n);
    return ({1'b0, n} + {{CLK_DIV_MAX_W{1'b0}}, 1'b1}) >> 1;
  endfunction

endpackage

// File: rtl/clk_neg_retime.sv
// rtl/clk_neg_retime.sv - single falling-edge retiming flop with synchronous active-low reset
module clk_neg_retime (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(negedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/clk_int_div_dyn.sv
// rtl/clk_int_div_dyn.sv - runtime-programmable integer clock divider, ratio loaded by valid/ready
// Optional 50% duty for odd ratios via macro CLK_INT_DIV_DYN_DUTY50_EN.
module clk_int_div_dyn
  import clk_div_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int DIV_INIT  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 clk_o
);

  clk_div_state_e r_state, w_state_nxt;

  logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt, w_cnt_step;
  logic [DIV_WIDTH-1:0] r_div, w_div_nxt;
  logic [DIV_WIDTH-1:0] r_pend, w_div_clamped;
  logic                 r_pend_vld;
  logic                 r_ready;
  logic                 r_start, w_start_nxt;
  logic                 r_clk_p, w_clk_p_nxt;
  logic                 w_accept, w_apply, w_boundary;
  logic [CLK_DIV_MAX_W:0] w_hi;

  assign w_accept      = div_valid_i & r_ready;
  assign w_div_clamped = (div_i < DIV_WIDTH'(CLK_DIV_MIN)) ? DIV_WIDTH'(CLK_DIV_MIN) : div_i;

  // r_start marks the first RUN edge after IDLE, which holds cnt at 0 so the first high phase is full.
  assign w_boundary = !r_start && (r_cnt == (r_div - DIV_WIDTH'(1)));
  assign w_cnt_step = (r_start || w_boundary) ? '0 : (r_cnt + DIV_WIDTH'(1));
  assign w_hi       = hi_cycles(CLK_DIV_MAX_W'(r_div));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clk_p_nxt = r_clk_p;
    w_start_nxt = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt   = '0;
        w_clk_p_nxt = 1'b0;
        w_apply     = r_pend_vld;
        if (en_i) begin
          w_state_nxt = RUN;
          w_start_nxt = 1'b1;
        end
      end
      RUN, DRAIN: begin
        w_cnt_nxt   = w_cnt_step;
        w_clk_p_nxt = ((CLK_DIV_MAX_W + 1)'(w_cnt_step) < w_hi);
        w_apply     = w_boundary & r_pend_vld;
        if (en_i) begin
          w_state_nxt = RUN;
        end else if (w_boundary) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_clk_p_nxt = 1'b0;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_clk_p_nxt = 1'b0;
      end
    endcase
  end

  assign w_div_nxt = w_apply ? r_pend : r_div;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_div      <= DIV_WIDTH'(DIV_INIT);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_ready    <= 1'b1;
      r_start    <= 1'b0;
      r_clk_p    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_start <= w_start_nxt;
      r_clk_p <= w_clk_p_nxt;
      // Ready re-opens one cycle after the pending ratio has been applied.
      if (w_accept) begin
        r_pend     <= w_div_clamped;
        r_pend_vld <= 1'b1;
        r_ready    <= 1'b0;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end else if (!r_pend_vld && !r_ready) begin
        r_ready <= 1'b1;
      end
    end
  end

`ifdef CLK_INT_DIV_DYN_DUTY50_EN
  logic w_clk_n;

  clk_neg_retime u_neg_retime (
    .i_clk  (clk_i),
    .i_rst_n(rst_n_i),
    .i_d    (r_clk_p),
    .o_q    (w_clk_n)
  );

  assign clk_o = r_div[0] ? (r_clk_p & w_clk_n) : r_clk_p;
`else
  assign clk_o = r_clk_p;
`endif

  assign div_o       = r_div;
  assign div_ready_o = r_ready;

endmodule

// File: tb/tb_clk_int_div_dyn.sv
// tb/tb_clk_int_div_dyn.sv - self-checking bench for clk_int_div_dyn, pulse widths in half source cycles
module tb_clk_int_div_dyn;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       en_i;
  logic       div_valid_i;
  logic       div_ready_o;
  logic [7:0] div_i;
  logic [7:0] div_o;
  logic       clk_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

`ifdef CLK_INT_DIV_DYN_DUTY50_EN
  localparam int H5 = 5, L5 = 5, L6_TO_5 = 7;
`else
  localparam int H5 = 6, L5 = 4, L6_TO_5 = 6;
`endif

  clk_int_div_dyn #(.DIV_WIDTH(8), .DIV_INIT(2)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .div_valid_i(div_valid_i),
    .div_ready_o(div_ready_o),
    .div_i      (div_i),
    .div_o      (div_o),
    .clk_o      (clk_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  // Length in half cycles of the current clk_o level; init counts samples already taken.
  task automatic run_len(input int init, output int n);
    logic lvl;
    lvl = clk_o;
    n   = init;
    for (int i = 0; i < 400; i++) begin
      #5;
      if (clk_o !== lvl) break;
      n++;
    end
  endtask

  task automatic meas(input string tag, input int init);
    int n;
    run_len(init, n);
    if (exp_q.size() == 0) chk({tag, "_no_expect"}, n, -1);
    else chk(tag, n, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int bad;
    int hi;
    int lo;
    rst_n_i = 1'b0; en_i = 1'b0; div_valid_i = 1'b0; div_i = '0;
    sync(); sync();
    chk("rst_clk_o", clk_o, 0);
    chk("rst_div_o", div_o, 2);
    chk("rst_ready", div_ready_o, 1);
    rst_n_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      sync();
      if (clk_o !== 1'b0 || div_o !== 8'd2 || div_ready_o !== 1'b1) bad++;
    end
    chk("idle_hold_bad_cycles", bad, 0);

    // load 4 in IDLE
    div_valid_i = 1'b1; div_i = 8'd4;
    sync();
    div_valid_i = 1'b0;
    chk("r4_ready_low", div_ready_o, 0);
    sync();
    chk("r4_applied", div_o, 4);
    chk("r4_ready_still_low", div_ready_o, 0);
    sync();
    chk("r4_ready_back", div_ready_o, 1);

    en_i = 1'b1;
    sync();
    chk("no_rise_on_en_edge", clk_o, 0);
    sync();
    chk("first_rise", clk_o, 1);
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4);
    meas("r4_hi0", 1); meas("r4_lo0", 1); meas("r4_hi1", 1); meas("r4_lo1", 1);

    // offer 6 during cnt=1 of a ratio-4 period
    hi = 1;
    #5; if (clk_o) hi++;
    #5; if (clk_o) hi++;
    div_valid_i = 1'b1; div_i = 8'd6;
    #5; if (clk_o) hi++;
    #5;
    div_valid_i = 1'b0;
    chk("r6_ready_low", div_ready_o, 0);
    exp_q.push_back(4); exp_q.push_back(4);
    chk("r4_last_hi", hi, exp_q.pop_front());
    meas("r4_last_lo", 1);
    chk("r6_switch_div_o", div_o, 6);
    chk("r6_ready_low_at_switch", div_ready_o, 0);
    #10;
    chk("r6_ready_back", div_ready_o, 1);
    exp_q.push_back(6); exp_q.push_back(6);
    meas("r6_hi0", 3); meas("r6_lo0", 1);

    // offer 5 at cnt=0 of a ratio-6 period
    div_valid_i = 1'b1; div_i = 8'd5;
    #10;
    div_valid_i = 1'b0;
    exp_q.push_back(6); exp_q.push_back(L6_TO_5);
    exp_q.push_back(H5); exp_q.push_back(L5); exp_q.push_back(H5); exp_q.push_back(L5);
    meas("r6_hi1", 3); meas("r6_lo_to5", 1);
    meas("r5_hi0", 1); meas("r5_lo0", 1); meas("r5_hi1", 1); meas("r5_lo1", 1);
    chk("r5_div_o", div_o, 5);

    en_i = 1'b0;
    repeat (12) sync();
    chk("drain_to_idle_clk", clk_o, 0);

    // ratio 1 clamps to 2
    div_valid_i = 1'b1; div_i = 8'd1;
    sync();
    div_valid_i = 1'b0;
    sync();
    chk("clamp_div_o", div_o, 2);
    sync();
    chk("clamp_ready_back", div_ready_o, 1);

    div_valid_i = 1'b1; div_i = 8'd6;
    sync();
    div_valid_i = 1'b0;
    sync(); sync();
    chk("r6b_div_o", div_o, 6);

    // drop en at cnt=0: full period then stay low
    en_i = 1'b1;
    sync(); sync();
    chk("r6b_rise", clk_o, 1);
    en_i = 1'b0;
    exp_q.push_back(6);
    meas("drain_hi", 1);
    lo = 0;
    for (int i = 0; i < 40; i++) begin
      if (clk_o === 1'b0) lo++;
      #5;
    end
    chk("drain_then_idle_low_halves", lo, 40);

    // reset mid-high with a pending ratio
    en_i = 1'b1;
    sync(); sync();
    chk("rerise", clk_o, 1);
    div_valid_i = 1'b1; div_i = 8'd3;
    sync();
    div_valid_i = 1'b0;
    chk("pend_ready_low", div_ready_o, 0);
    chk("mid_high", clk_o, 1);
    rst_n_i = 1'b0;
    sync();
    chk("midrst_clk_o", clk_o, 0);
    chk("midrst_div_o", div_o, 2);
    chk("midrst_ready", div_ready_o, 1);
    rst_n_i = 1'b1;
    sync(); sync();
    chk("post_rst_rise", clk_o, 1);
    exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
    meas("r2_hi0", 1); meas("r2_lo0", 1); meas("r2_hi1", 1); meas("r2_lo1", 1);
    chk("pend_discarded_div_o", div_o, 2);
    chk("pend_discarded_ready", div_ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
